a2d_arb: RTL and testbench
==========================

# a2d_arb

Two-requester arbiter and sequencer for the robot's single shared A2D converter. Requester 0 is `motion_cntrl` (IR sensor channels). Requester 1 is housekeeping (battery/supply monitor channels). The block grants the converter round-robin, latches the requested channel, issues the start pulse and waits for completion with a watchdog. It then returns the 12-bit result with a per-requester done pulse, and enforces a programmable idle gap between conversions.

## Interface
Parameters:
- `GAP`, default 4: idle cycles between the end of one conversion and the next grant; legal range 1..255.
- `TMO`, default 1023: maximum cycles spent in `WAIT` before the conversion is aborted; legal range 2..65535.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req0` input 1: level request from requester 0; held until `done0`.
- `chnnl0` input 3: channel for requester 0; sampled only at grant.
- `req1` input 1: level request from requester 1; held until `done1`.
- `chnnl1` input 3: channel for requester 1; sampled only at grant.
- `done0` output 1: one-cycle pulse; the result for requester 0 is valid.
- `done1` output 1: one-cycle pulse; the result for requester 1 is valid.
- `res` output 12: last conversion result; holds until the next completion.
- `tmo` output 1: qualifies `done0`/`done1`; when high, the conversion timed out and `res` is unchanged.
- `gnt` output 2: one-hot current owner; `00` when idle or in the gap.
- `strt_cnv` output 1: one-cycle start pulse to the converter.
- `chnnl` output 3: channel to the converter; stable from grant to completion.
- `cnv_cmplt` input 1: converter completion strobe.
- `A2D_res` input 12: converter result; valid in the `cnv_cmplt` cycle.

## Operation
- Reset values: `strt_cnv`=0, `chnnl`=0, `res`=0, `done0`=0, `done1`=0, `tmo`=0, `gnt`=00. State is `IDLE`. The `last` register is 1, so requester 0 wins the first tie.
- States: `IDLE`, `START`, `WAIT`, `GAP`.
- `IDLE` transitions:
  - Only one request is high: grant that requester.
  - Both requests are high: grant the requester that is not `last`.
  - On any grant: latch its channel into `chnnl`, set `gnt`, update `last`, and go to `START`.
  - `cnv_cmplt` is ignored in `IDLE`.
- `START`: `strt_cnv`=1 for exactly this cycle; clear the watchdog; go to `WAIT`.
- `WAIT` transitions:
  - On `cnv_cmplt`: `res`←`A2D_res`; pulse the owner's `done` with `tmo`=0; go to `GAP`.
  - Watchdog reaches `TMO` without `cnv_cmplt`: pulse the owner's `done` with `tmo`=1; `res` is unchanged; go to `GAP`.
  - If `cnv_cmplt` arrives in the same cycle the watchdog expires, completion wins.
- `GAP`: `gnt`=00. `chnnl` holds its last value. Count `GAP` cycles, then go to `IDLE`.
- A requester drops `req` in the cycle after it sees `done`. Because `GAP`≥1, a held `req` is never double-serviced.
- If a requester drops `req` mid-conversion, the conversion still completes and `done` still pulses. The result is discarded by the requester.
- `chnnl0`/`chnnl1` changes after grant have no effect.
- Reset asserted mid-conversion returns everything to reset values immediately. A stale `cnv_cmplt` after reset lands in `IDLE` and is ignored.

## Timing
- Request to start: `req` seen in `IDLE` at cycle N → `gnt`/`chnnl` valid and `strt_cnv`=1 at N+1 (registered outputs).
- `WAIT` begins at N+2. `cnv_cmplt` at cycle M → `res`/`done`/`tmo` at M+1 (registered).
- `GAP` spans M+1..M+GAP. The next grant is evaluated at M+GAP+1 and its `strt_cnv` appears at M+GAP+2.
- Timeout: the watchdog counts `WAIT` cycles starting at N+2. `done` with `tmo`=1 occurs TMO+1 cycles after `strt_cnv`.
- Best-case back-to-back throughput for conversion latency L: one conversion per L+GAP+2 cycles.
- `done0` and `done1` are never high together.

## Structure
- Package `a2d_arb_pkg`: state enum `a2d_arb_state_t` {IDLE, START, WAIT, GAP}, 2-bit encoding; `REQ_MOTION`=0, `REQ_HSK`=1 index constants.
- One sub-module, `a2d_arb_tmr`: a 16-bit load/decrement counter with a `zero` flag. It is loaded with `TMO` in `START` and with `GAP` on leaving `WAIT`, and is shared by the watchdog and the gap.
- The arbiter FSM, `last` register, and output registers live in `a2d_arb`.

## Test plan
- Single request: `req0`=1, `chnnl0`=3, model returns 12'hABC 20 cycles after `strt_cnv` → `chnnl`=3, one `strt_cnv` pulse, `done0` with `res`=12'hABC and `tmo`=0, `gnt`=01 during the conversion.
- Contention: `req0`/`req1` high together from reset, always re-raised → grant order 0,1,0,1. `strt_cnv` pulses are spaced by ≥ L+GAP+2 cycles.
- Timeout: `req1`=1, model never completes, `TMO`=50 → `done1` and `tmo`=1 exactly 51 cycles after `strt_cnv`. `res` keeps its prior value. The next grant proceeds normally.
- Coincidence: `cnv_cmplt` on the cycle the watchdog expires → `tmo`=0 and `res` is updated.
- Channel stability: change `chnnl0` from 1 to 7 after grant → `chnnl` stays 1 until `done0`.
- Reset mid-`WAIT`: drop `rst_n`, then a stale `cnv_cmplt` arrives → all outputs return to reset values, no `done` pulse, and the next `req0` is serviced normally.

Source files
------------

// File: rtl/a2d_arb_pkg.sv
// rtl/a2d_arb_pkg.sv - shared state type and requester constants for the A2D arbiter
package a2d_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } a2d_arb_state_t;

  localparam logic REQ_MOTION = 1'b0;
  localparam logic REQ_HSK    = 1'b1;

  function automatic logic [1:0] owner_onehot(input logic idx);
    return (idx == REQ_HSK) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/a2d_arb_if.sv
// rtl/a2d_arb_if.sv - requester and converter signals of the A2D arbiter
interface a2d_arb_if;

  logic        req0;
  logic [2:0]  chnnl0;
  logic        req1;
  logic [2:0]  chnnl1;
  logic        done0;
  logic        done1;
  logic [11:0] res;
  logic        tmo;
  logic [1:0]  gnt;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] A2D_res;

  modport slave (
    input  req0, chnnl0, req1, chnnl1, cnv_cmplt, A2D_res,
    output done0, done1, res, tmo, gnt, strt_cnv, chnnl
  );

  modport master (
    output req0, chnnl0, req1, chnnl1, cnv_cmplt, A2D_res,
    input  done0, done1, res, tmo, gnt, strt_cnv, chnnl
  );

endinterface

// File: rtl/a2d_arb_tmr.sv
// rtl/a2d_arb_tmr.sv - load/decrement counter shared by the watchdog and the idle gap
module a2d_arb_tmr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        dec_i,
  output logic        zero_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 16'd0);

endmodule

// File: rtl/a2d_arb.sv
// rtl/a2d_arb.sv - round-robin owner of the shared A2D converter with watchdog and idle gap
module a2d_arb #(
  parameter int GAP = 4,
  parameter int TMO = 1023
) (
  input logic      clk,
  input logic      rst_n,
  a2d_arb_if.slave bus
);

  import a2d_arb_pkg::*;

  // Counter runs to zero, so load one less than the number of cycles to span.
  localparam logic [15:0] TMO_LD = 16'(TMO - 1);
  localparam logic [15:0] GAP_LD = 16'(GAP - 1);

  a2d_arb_state_t state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [2:0]  chnnl_q, chnnl_d;
  logic [11:0] res_q, res_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        tmo_q, tmo_d;
  logic        strt_q, strt_d;
  logic        pick;
  logic        tmr_load;
  logic        tmr_dec;
  logic        tmr_zero;
  logic [15:0] tmr_val;

  a2d_arb_tmr u_tmr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .dec_i     (tmr_dec),
    .zero_o    (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    chnnl_d  = chnnl_q;
    res_d    = res_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    tmo_d    = 1'b0;
    strt_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = TMO_LD;
    pick     = (bus.req0 && bus.req1) ? ~last_q : (bus.req0 ? REQ_MOTION : REQ_HSK);

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_d = pick;
          last_d  = pick;
          gnt_d   = owner_onehot(pick);
          chnnl_d = (pick == REQ_HSK) ? bus.chnnl1 : bus.chnnl0;
          strt_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tmr_load = 1'b1;
        tmr_val  = TMO_LD;
        state_d  = WAIT;
      end
      WAIT: begin
        // Completion takes priority over a watchdog expiring in the same cycle.
        if (bus.cnv_cmplt || tmr_zero) begin
          res_d    = bus.cnv_cmplt ? bus.A2D_res : res_q;
          tmo_d    = ~bus.cnv_cmplt;
          done0_d  = (owner_q == REQ_MOTION);
          done1_d  = (owner_q == REQ_HSK);
          gnt_d    = 2'b00;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
          state_d  = a2d_arb_pkg::GAP;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      a2d_arb_pkg::GAP: begin
        if (tmr_zero) begin
          state_d = IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= REQ_MOTION;
      gnt_q   <= 2'b00;
      chnnl_q <= 3'd0;
      res_q   <= 12'd0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      tmo_q   <= 1'b0;
      strt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      chnnl_q <= chnnl_d;
      res_q   <= res_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      tmo_q   <= tmo_d;
      strt_q  <= strt_d;
    end
  end

  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.res      = res_q;
  assign bus.tmo      = tmo_q;
  assign bus.gnt      = gnt_q;
  assign bus.strt_cnv = strt_q;
  assign bus.chnnl    = chnnl_q;

endmodule

// File: tb/tb_a2d_arb.sv
// tb/tb_a2d_arb.sv - directed and randomized checks of a2d_arb against a transaction-level model
module tb_a2d_arb;

  localparam int GAP_P = 4;
  localparam int TMO_P = 50;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  a2d_arb_if ifc ();

  a2d_arb #(.GAP(GAP_P), .TMO(TMO_P)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task tick();
    @(posedge clk);
    #1;
  endtask

  task idle_inputs();
    ifc.req0      = 1'b0;
    ifc.req1      = 1'b0;
    ifc.chnnl0    = 3'd0;
    ifc.chnnl1    = 3'd0;
    ifc.cnv_cmplt = 1'b0;
    ifc.A2D_res   = 12'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) tick();
    n_checks++; if (ifc.strt_cnv !== 1'b0) begin n_fail++; $display("FAIL reset_strt: got %b want 0", ifc.strt_cnv); end
    n_checks++; if (ifc.chnnl !== 3'd0) begin n_fail++; $display("FAIL reset_chnnl: got %0d want 0", ifc.chnnl); end
    n_checks++; if (ifc.res !== 12'd0) begin n_fail++; $display("FAIL reset_res: got %h want 000", ifc.res); end
    n_checks++; if (ifc.done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done0: got %b want 0", ifc.done0); end
    n_checks++; if (ifc.done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done1: got %b want 0", ifc.done1); end
    n_checks++; if (ifc.tmo !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %b want 0", ifc.tmo); end
    n_checks++; if (ifc.gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", ifc.gnt); end
    rst_n = 1'b1;
    tick();
    n_checks++; if ({ifc.strt_cnv, ifc.gnt} !== 3'b000) begin n_fail++; $display("FAIL reset_idle: got %b want 000", {ifc.strt_cnv, ifc.gnt}); end
  endtask

  task automatic test_single();
    ifc.chnnl0 = 3'd3;
    ifc.req0   = 1'b1;
    tick();
    n_checks++; if (ifc.strt_cnv !== 1'b1) begin n_fail++; $display("FAIL single_strt: got %b want 1", ifc.strt_cnv); end
    n_checks++; if (ifc.gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b want 01", ifc.gnt); end
    n_checks++; if (ifc.chnnl !== 3'd3) begin n_fail++; $display("FAIL single_chnnl: got %0d want 3", ifc.chnnl); end
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_checks++;
      if ({ifc.strt_cnv, ifc.gnt, ifc.done1, ifc.done0} !== 5'b0_01_00) begin
        n_fail++; $display("FAIL single_wait k=%0d: got %b want 00100", k, {ifc.strt_cnv, ifc.gnt, ifc.done1, ifc.done0});
      end
    end
    ifc.cnv_cmplt = 1'b1;
    ifc.A2D_res   = 12'hABC;
    tick();
    ifc.cnv_cmplt = 1'b0;
    n_checks++; if ({ifc.done0, ifc.done1, ifc.tmo} !== 3'b100) begin n_fail++; $display("FAIL single_done: got %b want 100", {ifc.done0, ifc.done1, ifc.tmo}); end
    n_checks++; if (ifc.res !== 12'hABC) begin n_fail++; $display("FAIL single_res: got %h want abc", ifc.res); end
    n_checks++; if (ifc.gnt !== 2'b00) begin n_fail++; $display("FAIL single_gap_gnt: got %b want 00", ifc.gnt); end
    tick();
    n_checks++; if (ifc.done0 !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b want 0", ifc.done0); end
    ifc.req0 = 1'b0;
    for (int k = 0; k < GAP_P + 4; k++) begin
      tick();
      n_checks++; if (ifc.strt_cnv !== 1'b0) begin n_fail++; $display("FAIL single_no_repeat k=%0d: got %b want 0", k, ifc.strt_cnv); end
    end
  endtask

  task automatic test_timeout();
    int s;
    ifc.chnnl1 = 3'd5;
    ifc.req1   = 1'b1;
    tick();
    n_checks++; if ({ifc.strt_cnv, ifc.gnt, ifc.chnnl} !== {1'b1, 2'b10, 3'd5}) begin n_fail++; $display("FAIL tmo_grant: got %b want 1_10_101", {ifc.strt_cnv, ifc.gnt, ifc.chnnl}); end
    s = cyc;
    for (int k = 0; k < 200 && ifc.done1 !== 1'b1; k++) tick();
    n_checks++; if (ifc.done1 !== 1'b1) begin n_fail++; $display("FAIL tmo_done1: got %b want 1 (bound expired)", ifc.done1); end
    n_checks++; if (cyc - s !== TMO_P + 1) begin n_fail++; $display("FAIL tmo_latency: got %0d want %0d", cyc - s, TMO_P + 1); end
    n_checks++; if ({ifc.tmo, ifc.done0} !== 2'b10) begin n_fail++; $display("FAIL tmo_flag: got %b want 10", {ifc.tmo, ifc.done0}); end
    n_checks++; if (ifc.res !== 12'hABC) begin n_fail++; $display("FAIL tmo_res_kept: got %h want abc", ifc.res); end
    tick();
    ifc.req1 = 1'b0;
    repeat (GAP_P) tick();
    ifc.chnnl0 = 3'd2;
    ifc.req0   = 1'b1;
    for (int k = 0; k < 20 && ifc.strt_cnv !== 1'b1; k++) tick();
    n_checks++; if ({ifc.strt_cnv, ifc.gnt, ifc.chnnl} !== {1'b1, 2'b01, 3'd2}) begin n_fail++; $display("FAIL tmo_next_grant: got %b want 1_01_010", {ifc.strt_cnv, ifc.gnt, ifc.chnnl}); end
    repeat (5) tick();
    ifc.cnv_cmplt = 1'b1;
    ifc.A2D_res   = 12'h123;
    tick();
    ifc.cnv_cmplt = 1'b0;
    n_checks++; if ({ifc.done0, ifc.tmo, ifc.res} !== {1'b1, 1'b0, 12'h123}) begin n_fail++; $display("FAIL tmo_next_done: got %h want %h", {ifc.done0, ifc.tmo, ifc.res}, {1'b1, 1'b0, 12'h123}); end
    tick();
    ifc.req0 = 1'b0;
    repeat (GAP_P + 2) tick();
  endtask

  task automatic test_coincidence();
    ifc.chnnl0 = 3'd1;
    ifc.req0   = 1'b1;
    tick();
    n_checks++; if ({ifc.strt_cnv, ifc.chnnl} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL coin_grant: got %b want 1_001", {ifc.strt_cnv, ifc.chnnl}); end
    ifc.chnnl0 = 3'd7;
    for (int k = 1; k <= TMO_P; k++) begin
      tick();
      n_checks++;
      if ({ifc.chnnl, ifc.done0} !== {3'd1, 1'b0}) begin
        n_fail++; $display("FAIL coin_chnnl_hold k=%0d: got %b want 001_0", k, {ifc.chnnl, ifc.done0});
      end
    end
    ifc.cnv_cmplt = 1'b1;
    ifc.A2D_res   = 12'h5A5;
    tick();
    ifc.cnv_cmplt = 1'b0;
    n_checks++; if ({ifc.done0, ifc.tmo} !== 2'b10) begin n_fail++; $display("FAIL coin_done: got %b want 10", {ifc.done0, ifc.tmo}); end
    n_checks++; if (ifc.res !== 12'h5A5) begin n_fail++; $display("FAIL coin_res: got %h want 5a5", ifc.res); end
    n_checks++; if (ifc.chnnl !== 3'd1) begin n_fail++; $display("FAIL coin_chnnl_after: got %0d want 1", ifc.chnnl); end
    tick();
    ifc.req0 = 1'b0;
    repeat (GAP_P + 2) tick();
  endtask

  task automatic test_contention();
    int prev;
    int lat;
    lat  = 8;
    prev = 0;
    rst_n = 1'b0;
    ifc.chnnl0 = 3'd2;
    ifc.chnnl1 = 3'd6;
    ifc.req0   = 1'b1;
    ifc.req1   = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 40 && ifc.strt_cnv !== 1'b1; k++) tick();
      n_checks++; if (ifc.strt_cnv !== 1'b1) begin n_fail++; $display("FAIL cont_strt t=%0d: got %b want 1", t, ifc.strt_cnv); end
      n_checks++;
      if ({ifc.gnt, ifc.chnnl} !== ((t % 2 == 1) ? {2'b10, 3'd6} : {2'b01, 3'd2})) begin
        n_fail++; $display("FAIL cont_order t=%0d: got %b want %b", t, {ifc.gnt, ifc.chnnl}, ((t % 2 == 1) ? {2'b10, 3'd6} : {2'b01, 3'd2}));
      end
      if (t > 0) begin
        n_checks++; if (cyc - prev !== lat + GAP_P + 2) begin n_fail++; $display("FAIL cont_spacing t=%0d: got %0d want %0d", t, cyc - prev, lat + GAP_P + 2); end
      end
      prev = cyc;
      repeat (lat) tick();
      ifc.cnv_cmplt = 1'b1;
      ifc.A2D_res   = 12'(t * 16 + 5);
      tick();
      ifc.cnv_cmplt = 1'b0;
      n_checks++;
      if ({ifc.done1, ifc.done0, ifc.res} !== {((t % 2 == 1) ? 2'b10 : 2'b01), 12'(t * 16 + 5)}) begin
        n_fail++; $display("FAIL cont_done t=%0d: got %h want %h", t, {ifc.done1, ifc.done0, ifc.res}, {((t % 2 == 1) ? 2'b10 : 2'b01), 12'(t * 16 + 5)});
      end
      tick();
      if (t % 2 == 1) ifc.req1 = 1'b0; else ifc.req0 = 1'b0;
      tick();
      if (t % 2 == 1) ifc.req1 = 1'b1; else ifc.req0 = 1'b1;
    end
    ifc.req0 = 1'b0;
    ifc.req1 = 1'b0;
    repeat (GAP_P + 2) tick();
    n_checks++; if (ifc.gnt !== 2'b00) begin n_fail++; $display("FAIL cont_drain: got %b want 00", ifc.gnt); end
  endtask

  task automatic test_reset_mid();
    ifc.chnnl0 = 3'd4;
    ifc.req0   = 1'b1;
    tick();
    n_checks++; if (ifc.strt_cnv !== 1'b1) begin n_fail++; $display("FAIL rmid_strt: got %b want 1", ifc.strt_cnv); end
    repeat (5) tick();
    rst_n    = 1'b0;
    ifc.req0 = 1'b0;
    #1;
    n_checks++;
    if ({ifc.strt_cnv, ifc.chnnl, ifc.res, ifc.done0, ifc.done1, ifc.tmo, ifc.gnt} !== 21'd0) begin
      n_fail++; $display("FAIL rmid_async: got %h want 0", {ifc.strt_cnv, ifc.chnnl, ifc.res, ifc.done0, ifc.done1, ifc.tmo, ifc.gnt});
    end
    tick();
    tick();
    rst_n         = 1'b1;
    ifc.cnv_cmplt = 1'b1;
    ifc.A2D_res   = 12'hFFF;
    tick();
    ifc.cnv_cmplt = 1'b0;
    n_checks++;
    if ({ifc.done0, ifc.done1, ifc.tmo, ifc.res, ifc.gnt, ifc.strt_cnv} !== 18'd0) begin
      n_fail++; $display("FAIL rmid_stale: got %h want 0", {ifc.done0, ifc.done1, ifc.tmo, ifc.res, ifc.gnt, ifc.strt_cnv});
    end
    tick();
    ifc.chnnl0 = 3'd6;
    ifc.req0   = 1'b1;
    tick();
    n_checks++; if ({ifc.strt_cnv, ifc.gnt, ifc.chnnl} !== {1'b1, 2'b01, 3'd6}) begin n_fail++; $display("FAIL rmid_regrant: got %b want 1_01_110", {ifc.strt_cnv, ifc.gnt, ifc.chnnl}); end
    repeat (3) tick();
    ifc.cnv_cmplt = 1'b1;
    ifc.A2D_res   = 12'h321;
    tick();
    ifc.cnv_cmplt = 1'b0;
    n_checks++; if ({ifc.done0, ifc.done1, ifc.tmo, ifc.res} !== {3'b100, 12'h321}) begin n_fail++; $display("FAIL rmid_done: got %h want %h", {ifc.done0, ifc.done1, ifc.tmo, ifc.res}, {3'b100, 12'h321}); end
    tick();
    ifc.req0 = 1'b0;
    repeat (GAP_P + 2) tick();
  endtask

  // Transaction model: each grant fixes start, completion and done cycles up front.
  task automatic test_random();
    logic        req_m[2];
    logic [2:0]  ch_m[2];
    int          drop_at[2];
    logic        busy, last_m, owner_m, tmo_m, pick, cmplt;
    logic [2:0]  chnnl_m;
    logic [11:0] res_m, res_val_m;
    int          strt_at, cmplt_at, done_at, free_at, lat;
    logic [1:0]  e_gnt;
    logic [4:0]  e_ctrl;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin req_m[r] = 1'b0; ch_m[r] = 3'd0; drop_at[r] = -1; end
    busy = 1'b0; last_m = 1'b1; owner_m = 1'b0; tmo_m = 1'b0; chnnl_m = 3'd0;
    res_m = 12'd0; res_val_m = 12'd0; strt_at = -1; cmplt_at = -1; done_at = -1; free_at = 0;
    for (int c = 0; c < 3000; c++) begin
      e_gnt = (busy && c >= strt_at && c < done_at) ? (owner_m ? 2'b10 : 2'b01) : 2'b00;
      e_ctrl = {busy && c == strt_at, e_gnt, busy && c == done_at && owner_m,
                busy && c == done_at && !owner_m};
      if (busy && c == done_at && !tmo_m) res_m = res_val_m;
      n_checks++;
      if ({ifc.strt_cnv, ifc.gnt, ifc.done1, ifc.done0, ifc.tmo} !== {e_ctrl, busy && c == done_at && tmo_m}) begin
        n_fail++; $display("FAIL rnd_ctrl c=%0d: got %b want %b", c, {ifc.strt_cnv, ifc.gnt, ifc.done1, ifc.done0, ifc.tmo}, {e_ctrl, busy && c == done_at && tmo_m});
      end
      n_checks++;
      if ({ifc.chnnl, ifc.res} !== {chnnl_m, res_m}) begin
        n_fail++; $display("FAIL rnd_data c=%0d: got %h want %h", c, {ifc.chnnl, ifc.res}, {chnnl_m, res_m});
      end
      if (busy && c == done_at) begin
        busy = 1'b0;
        free_at = c + GAP_P;
        drop_at[owner_m] = c + 1;
      end
      for (int r = 0; r < 2; r++) begin
        if (req_m[r] && drop_at[r] == c) req_m[r] = 1'b0;
        else if (!req_m[r] && drop_at[r] < c && $urandom_range(0, 4) == 0) req_m[r] = 1'b1;
        if ($urandom_range(0, 2) == 0) ch_m[r] = 3'($urandom_range(0, 7));
      end
      cmplt = busy && c == cmplt_at;
      if (!busy && c >= free_at && $urandom_range(0, 7) == 0) cmplt = 1'b1;
      ifc.A2D_res = (busy && c == cmplt_at) ? res_val_m : 12'($urandom);
      if (!busy && c >= free_at && (req_m[0] || req_m[1])) begin
        pick    = (req_m[0] && req_m[1]) ? !last_m : req_m[1];
        owner_m = pick;
        last_m  = pick;
        chnnl_m = ch_m[pick];
        strt_at = c + 1;
        lat = ($urandom_range(0, 3) == 0) ? $urandom_range(TMO_P - 1, TMO_P + 3) : $urandom_range(1, 20);
        if (lat <= TMO_P) begin
          cmplt_at  = c + 1 + lat;
          done_at   = c + 2 + lat;
          tmo_m     = 1'b0;
          res_val_m = 12'($urandom);
        end else begin
          cmplt_at = -1;
          done_at  = c + 2 + TMO_P;
          tmo_m    = 1'b1;
        end
        busy = 1'b1;
      end
      ifc.req0      = req_m[0];
      ifc.req1      = req_m[1];
      ifc.chnnl0    = ch_m[0];
      ifc.chnnl1    = ch_m[1];
      ifc.cnv_cmplt = cmplt;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_timeout();
    test_coincidence();
    test_contention();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
